fifo_burst_writer: RTL and testbench
====================================

Name: fifo_burst_writer

Overview:
Write-domain producer that frames upstream data into bursts and pushes them into the async FIFO write port (we/wdata/full). Each burst is a header word holding the payload length, followed by that many payload words taken from a valid/ready source. An optional checksum trailer can follow the payload. The block runs entirely on wclk and sits between the write-domain datapath and the FIFO.

Parameters:
WIDTH, 4, data word width; matches FIFO WIDTH; the header and length are also WIDTH bits wide.

Ports:
wclk  input  1  write-domain clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request a burst; sampled only in IDLE
len  input  WIDTH  payload word count, 0..2^WIDTH-1; captured when start is accepted
busy  output  1  burst in progress (HEADER/PAYLOAD/TRAILER/DONE)
done  output  1  one-cycle pulse after the final word of a burst is written
src_valid  input  1  upstream word available
src_data  input  WIDTH  upstream word
src_ready  output  1  upstream word consumed this cycle when src_valid is also high
full  input  1  FIFO full flag, wclk domain
we  output  1  FIFO write enable
wdata  output  WIDTH  FIFO write data

Behaviour:
- States: IDLE, HEADER, PAYLOAD, TRAILER (only with the macro), DONE. Registered state, remaining-count register cnt (WIDTH bits) and captured-length register.
- Reset (async): state=IDLE, cnt=0. Outputs: busy=0, done=0, we=0, src_ready=0, wdata=0.
- IDLE: start=1 captures len into cnt and moves to HEADER on the next edge. busy stays 0 during the start cycle.
- start outside IDLE is ignored; no queuing.
- HEADER: we = ~full, wdata = captured len.
  - On an accepted write (we=1): go to PAYLOAD if cnt!=0.
  - If cnt==0: go to TRAILER (macro on) or DONE (macro off).
- PAYLOAD:
  - src_ready = ~full; we = src_valid & ~full; wdata = src_data.
  - Each transfer (src_valid & src_ready) decrements cnt.
  - The transfer with cnt==1 leaves for TRAILER or DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in DONE.
- Invariants:
  - we is never 1 while full=1.
  - we is combinational from state, full and src_valid; there is no write latency beyond the FIFO's own.
  - src_ready=0 outside PAYLOAD.
  - wdata=0 when we=0.
- full may rise or fall on any cycle. The FSM simply stalls in its current state with no word lost or duplicated.
- A src_valid gap stalls PAYLOAD without a timeout.
- Minimum burst duration is len+2 cycles (+1 with trailer) when full=0 and src_valid is always 1.
- Reset mid-burst abandons the burst. Words already written stay in the FIFO, and no done pulse is issued.

Optional Feature:
FIFO_WRITER_CSUM_EN
- Defined: TRAILER state is present. An accumulator is cleared at start acceptance and XORs the header word and every payload word. TRAILER writes the accumulator (we = ~full), then goes to DONE. Burst length on the FIFO is len+2 words.
- Undefined: no accumulator and no TRAILER state. Burst length is len+1 words.

Test Plan:
- Basic burst: full=0, src_valid=1, start with len=3, src_data 0xA,0xB,0xC → FIFO receives 0x3,0xA,0xB,0xC on consecutive cycles. done pulses once, 1 cycle after the 0xC write.
- Zero length: start with len=0 → single write 0x0, then done. src_ready never asserted.
- Backpressure: len=2, full held high for 3 cycles in HEADER and 2 cycles mid-payload → we stays 0 while full=1. Output sequence is exactly 0x2,d0,d1 with no drops or duplicates.
- Source gaps: len=4, src_valid toggling 1010… → we only when src_valid=1. 4 payload words written in order. cnt does not decrement on gaps.
- Start while busy and reset mid-burst: a second start during PAYLOAD is ignored. rst asserted after 1 payload word → busy/we/done/src_ready go to 0 immediately, state IDLE. A new burst of len=1 then works normally.
- Macro defined: len=2, data 0x5,0x6 → writes 0x2,0x5,0x6 then trailer 0x1 (2^5^6). done follows the trailer.

Source files
------------

// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer: frames a valid/ready source into bursts for an async FIFO
// write port. A burst is a header word (payload length) followed by that many
// payload words. Optional feature macro: FIFO_WRITER_CSUM_EN, which adds an
// XOR checksum trailer word after the payload.
module fifo_burst_writer #(
    parameter int WIDTH = 4
) (
    input  logic             wclk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    input  logic             full,
    output logic             we,
    output logic [WIDTH-1:0] wdata
);

`ifdef FIFO_WRITER_CSUM_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_TRAILER = 3'd3,
        S_DONE    = 3'd4
    } state_t;
    // After the last payload word (or an empty header) the checksum follows.
    localparam state_t S_TAIL = S_TRAILER;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_DONE    = 3'd4
    } state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] len_q, len_d;
`ifdef FIFO_WRITER_CSUM_EN
    logic [WIDTH-1:0] acc_q, acc_d;
`endif

    // Next-state logic and output decode. Writes are gated by full in the
    // same cycle so a stall simply holds the state with nothing lost.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
`ifdef FIFO_WRITER_CSUM_EN
        acc_d     = acc_q;
`endif
        busy      = 1'b0;
        done      = 1'b0;
        src_ready = 1'b0;
        we        = 1'b0;
        wdata     = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = len;
`ifdef FIFO_WRITER_CSUM_EN
                    acc_d   = '0;
`endif
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                busy = 1'b1;
                we   = ~full;
                if (!full) begin
                    wdata = len_q;
`ifdef FIFO_WRITER_CSUM_EN
                    acc_d = acc_q ^ len_q;
`endif
                    state_d = (cnt_q != '0) ? S_PAYLOAD : S_TAIL;
                end
            end
            S_PAYLOAD: begin
                busy      = 1'b1;
                src_ready = ~full;
                we        = src_valid & ~full;
                if (src_valid && !full) begin
                    wdata = src_data;
                    cnt_d = cnt_q - WIDTH'(1);
`ifdef FIFO_WRITER_CSUM_EN
                    acc_d = acc_q ^ src_data;
`endif
                    if (cnt_q == WIDTH'(1)) begin
                        state_d = S_TAIL;
                    end
                end
            end
`ifdef FIFO_WRITER_CSUM_EN
            S_TRAILER: begin
                busy = 1'b1;
                we   = ~full;
                if (!full) begin
                    wdata   = acc_q;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, remaining count, captured length (and checksum) registers.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef FIFO_WRITER_CSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
`ifdef FIFO_WRITER_CSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Table-driven bench for fifo_burst_writer: each row gives one cycle of
// inputs and the outputs expected in that cycle. Checksum rows are added
// when FIFO_WRITER_CSUM_EN is defined.
module tb_fifo_burst_writer;

    logic       wclk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       busy;
    logic       done;
    logic       src_valid;
    logic [3:0] src_data;
    logic       src_ready;
    logic       full;
    logic       we;
    logic [3:0] wdata;

    int tests_run = 0;
    int tests_failed = 0;
    int vec_no = 0;

    typedef struct {
        logic       start;
        logic [3:0] len;
        logic       sv;
        logic [3:0] sd;
        logic       full;
        logic       busy;
        logic       done;
        logic       we;
        logic [3:0] wd;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    fifo_burst_writer #(.WIDTH(4)) dut (
        .wclk      (wclk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .full      (full),
        .we        (we),
        .wdata     (wdata)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [3:0] ln, input logic sv, input logic [3:0] sd,
                       input logic fl, input logic eb, input logic ed, input logic ew,
                       input logic [3:0] ewd, input logic er);
        vec_t v;
        v.start = st; v.len = ln; v.sv = sv; v.sd = sd; v.full = fl;
        v.busy = eb; v.done = ed; v.we = ew; v.wd = ewd; v.rdy = er;
        vecs.push_back(v);
    endtask

    // Apply every queued row, one per clock, comparing outputs mid-cycle.
    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge wclk);
            start     = vecs[i].start;
            len       = vecs[i].len;
            src_valid = vecs[i].sv;
            src_data  = vecs[i].sd;
            full      = vecs[i].full;
            #1;
            chk("busy",      vec_no, {3'b0, busy},      {3'b0, vecs[i].busy});
            chk("done",      vec_no, {3'b0, done},      {3'b0, vecs[i].done});
            chk("we",        vec_no, {3'b0, we},        {3'b0, vecs[i].we});
            chk("wdata",     vec_no, wdata,             vecs[i].wd);
            chk("src_ready", vec_no, {3'b0, src_ready}, {3'b0, vecs[i].rdy});
            $display("[TB] vec %0d start=%0b len=%h sv=%0b sd=%h full=%0b -> busy=%0b done=%0b we=%0b wdata=%h rdy=%0b",
                     vec_no, start, len, src_valid, src_data, full, busy, done, we, wdata, src_ready);
            vec_no++;
        end
        vecs.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; src_valid = 1'b0; src_data = '0; full = 1'b0;
        @(negedge wclk);
        #1;
        chk("rst_busy",  -1, {3'b0, busy},      4'h0);
        chk("rst_done",  -1, {3'b0, done},      4'h0);
        chk("rst_we",    -1, {3'b0, we},        4'h0);
        chk("rst_wdata", -1, wdata,             4'h0);
        chk("rst_rdy",   -1, {3'b0, src_ready}, 4'h0);
        @(negedge wclk);
        rst = 1'b0;

        // Basic burst: 3, A, B, C
        add(1, 4'h3, 1, 4'h0, 0,  0, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h0, 0,  1, 0, 1, 4'h3, 0);
        add(0, 4'h0, 1, 4'hA, 0,  1, 0, 1, 4'hA, 1);
        add(0, 4'h0, 1, 4'hB, 0,  1, 0, 1, 4'hB, 1);
        add(0, 4'h0, 1, 4'hC, 0,  1, 0, 1, 4'hC, 1);
`ifdef FIFO_WRITER_CSUM_EN
        add(0, 4'h0, 1, 4'h0, 0,  1, 0, 1, 4'hE, 0);   // 3^A^B^C
`endif
        add(0, 4'h0, 1, 4'h0, 0,  1, 1, 0, 4'h0, 0);
        add(0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 4'h0, 0);

        // Zero length: header 0 only, src_ready never high
        add(1, 4'h0, 1, 4'h5, 0,  0, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h5, 0,  1, 0, 1, 4'h0, 0);
`ifdef FIFO_WRITER_CSUM_EN
        add(0, 4'h0, 1, 4'h5, 0,  1, 0, 1, 4'h0, 0);
`endif
        add(0, 4'h0, 1, 4'h5, 0,  1, 1, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h5, 0,  0, 0, 0, 4'h0, 0);

        // Backpressure: full 3 cycles in header, 2 cycles mid-payload
        add(1, 4'h2, 1, 4'h7, 0,  0, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h7, 1,  1, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h7, 1,  1, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h7, 1,  1, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h7, 0,  1, 0, 1, 4'h2, 0);
        add(0, 4'h0, 1, 4'h7, 0,  1, 0, 1, 4'h7, 1);
        add(0, 4'h0, 1, 4'h9, 1,  1, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h9, 1,  1, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h9, 0,  1, 0, 1, 4'h9, 1);
`ifdef FIFO_WRITER_CSUM_EN
        add(0, 4'h0, 0, 4'h0, 1,  1, 0, 0, 4'h0, 0);   // trailer stalled
        add(0, 4'h0, 0, 4'h0, 0,  1, 0, 1, 4'hC, 0);   // 2^7^9
`endif
        add(0, 4'h0, 0, 4'h0, 0,  1, 1, 0, 4'h0, 0);
        add(0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 4'h0, 0);

        // Source gaps with a start during PAYLOAD that must be ignored
        add(1, 4'h4, 1, 4'h1, 0,  0, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h1, 0,  1, 0, 1, 4'h4, 0);
        add(0, 4'h0, 1, 4'h1, 0,  1, 0, 1, 4'h1, 1);
        add(1, 4'h7, 0, 4'hF, 0,  1, 0, 0, 4'h0, 1);
        add(0, 4'h0, 1, 4'h2, 0,  1, 0, 1, 4'h2, 1);
        add(0, 4'h0, 0, 4'hF, 0,  1, 0, 0, 4'h0, 1);
        add(0, 4'h0, 1, 4'h3, 0,  1, 0, 1, 4'h3, 1);
        add(0, 4'h0, 0, 4'hF, 0,  1, 0, 0, 4'h0, 1);
        add(0, 4'h0, 1, 4'h4, 0,  1, 0, 1, 4'h4, 1);
`ifdef FIFO_WRITER_CSUM_EN
        add(0, 4'h0, 0, 4'h0, 0,  1, 0, 1, 4'h0, 0);   // 4^1^2^3^4
`endif
        add(0, 4'h0, 0, 4'h0, 0,  1, 1, 0, 4'h0, 0);
        add(0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 4'h0, 0);

        // len=2 with data 5,6 (trailer 2^5^6 = 1 when enabled)
        add(1, 4'h2, 1, 4'h5, 0,  0, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h5, 0,  1, 0, 1, 4'h2, 0);
        add(0, 4'h0, 1, 4'h5, 0,  1, 0, 1, 4'h5, 1);
        add(0, 4'h0, 1, 4'h6, 0,  1, 0, 1, 4'h6, 1);
`ifdef FIFO_WRITER_CSUM_EN
        add(0, 4'h0, 1, 4'h6, 0,  1, 0, 1, 4'h1, 0);
`endif
        add(0, 4'h0, 1, 4'h6, 0,  1, 1, 0, 4'h0, 0);
        add(0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 4'h0, 0);
        run_vecs();

        // Reset mid-burst: len=3, one payload word, then asynchronous rst
        add(1, 4'h3, 1, 4'h8, 0,  0, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'h8, 0,  1, 0, 1, 4'h3, 0);
        add(0, 4'h0, 1, 4'h8, 0,  1, 0, 1, 4'h8, 1);
        run_vecs();
        @(negedge wclk);
        src_valid = 1'b1; src_data = 4'h9; start = 1'b0; full = 1'b0;
        #1;
        chk("pre_rst_we", -2, {3'b0, we}, 4'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  -2, {3'b0, busy},      4'h0);
        chk("mid_rst_we",    -2, {3'b0, we},        4'h0);
        chk("mid_rst_done",  -2, {3'b0, done},      4'h0);
        chk("mid_rst_rdy",   -2, {3'b0, src_ready}, 4'h0);
        chk("mid_rst_wdata", -2, wdata,             4'h0);
        $display("[TB] reset asserted mid-burst: busy=%0b we=%0b done=%0b rdy=%0b", busy, we, done, src_ready);
        @(negedge wclk);
        rst = 1'b0;

        // Fresh len=1 burst after reset; full during DONE has no effect
        add(0, 4'h0, 1, 4'hD, 0,  0, 0, 0, 4'h0, 0);
        add(1, 4'h1, 1, 4'hD, 0,  0, 0, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'hD, 0,  1, 0, 1, 4'h1, 0);
        add(0, 4'h0, 1, 4'hD, 0,  1, 0, 1, 4'hD, 1);
`ifdef FIFO_WRITER_CSUM_EN
        add(0, 4'h0, 1, 4'hD, 0,  1, 0, 1, 4'hC, 0);   // 1^D
`endif
        add(0, 4'h0, 1, 4'hD, 1,  1, 1, 0, 4'h0, 0);
        add(0, 4'h0, 1, 4'hD, 0,  0, 0, 0, 4'h0, 0);
        add(0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 4'h0, 0);
        run_vecs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
